// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - sequenced register-file datapath with shifter, ALU and status flags
// One operation runs IDLE -> LOADA -> LOADB -> EXEC -> WB, and each stage uses only the latched instruction.
module datapath_seq #(
   parameter int W    = 16,
   parameter int NREG = 8,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [2:0]    op,
   input  logic [AW-1:0] rd,
   input  logic [AW-1:0] rn,
   input  logic [AW-1:0] rm,
   input  logic [1:0]    shift,
   input  logic [W-1:0]  imm,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  datapath_out,
   output logic [2:0]    status,
   input  logic [AW-1:0] dbg_num,
   output logic [W-1:0]  dbg_data
);

   typedef enum logic [2:0] {S_IDLE, S_LOADA, S_LOADB, S_EXEC, S_WB} state_t;

   localparam logic [2:0] OP_MOVI = 3'b000;
   localparam logic [2:0] OP_MOV  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_CMP  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_MVN  = 3'b101;

   state_t          state, state_nxt;
   logic [W-1:0]    rf [NREG];
   logic [2:0]      ir_op;
   logic [AW-1:0]   ir_rd, ir_rn, ir_rm;
   logic [1:0]      ir_shift;
   logic [W-1:0]    ir_imm;
   logic [W-1:0]    a, b, c;
   logic [2:0]      st;
   logic [W-1:0]    bs, diff;
   logic            ovf, wr_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = S_LOADA;
         end
         S_LOADA: state_nxt = S_LOADB;
         S_LOADB: state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_WB;
         S_WB: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      case (ir_shift)
         2'b01:   bs = {b[W-2:0], 1'b0};
         2'b10:   bs = {1'b0, b[W-1:1]};
         2'b11:   bs = {b[W-1], b[W-1:1]};
         default: bs = b;
      endcase
   end

   assign diff  = a - bs;
   assign ovf   = (a[W-1] != bs[W-1]) && (diff[W-1] != a[W-1]);
   assign wr_en = (ir_op == OP_MOVI) || (ir_op == OP_MOV) || (ir_op == OP_ADD) ||
                  (ir_op == OP_AND)  || (ir_op == OP_MVN);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir_op    <= '0;
         ir_rd    <= '0;
         ir_rn    <= '0;
         ir_rm    <= '0;
         ir_shift <= '0;
         ir_imm   <= '0;
         a        <= '0;
         b        <= '0;
         c        <= '0;
         st       <= '0;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  ir_op    <= op;
                  ir_rd    <= rd;
                  ir_rn    <= rn;
                  ir_rm    <= rm;
                  ir_shift <= shift;
                  ir_imm   <= imm;
               end
            end
            S_LOADA: a <= rf[ir_rn];
            S_LOADB: b <= rf[ir_rm];
            S_EXEC: begin
               case (ir_op)
                  OP_MOVI: c  <= ir_imm;
                  OP_MOV:  c  <= bs;
                  OP_ADD:  c  <= a + bs;
                  OP_CMP:  st <= {ovf, diff[W-1], (diff == '0)};
                  OP_AND:  c  <= a & bs;
                  OP_MVN:  c  <= ~bs;
                  default: ;
               endcase
            end
            S_WB: begin
               if (wr_en) rf[ir_rd] <= c;
            end
            default: ;
         endcase
      end
   end

   assign datapath_out = c;
   assign status       = st;
   assign dbg_data     = rf[dbg_num];

endmodule

// File: tb/tb_datapath_seq.sv
// tb/tb_datapath_seq.sv - directed plus randomized self-checking bench for datapath_seq
// Expected values come from an arithmetic model of the register file, C register and flags.
module tb_datapath_seq;
   localparam int W    = 16;
   localparam int NREG = 8;
   localparam int AW   = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    op = '0;
   logic [AW-1:0] rd = '0, rn = '0, rm = '0, dbg_num = '0;
   logic [1:0]    shift = '0;
   logic [W-1:0]  imm = '0;
   logic          busy, done;
   logic [W-1:0]  datapath_out, dbg_data;
   logic [2:0]    status;

   int checks = 0;
   int errors = 0;
   int unsigned m_rf [NREG];
   int unsigned m_c;
   logic [2:0]  m_st;

   datapath_seq #(.W(W), .NREG(NREG)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .rd(rd), .rn(rn), .rm(rm),
      .shift(shift), .imm(imm), .busy(busy), .done(done), .datapath_out(datapath_out),
      .status(status), .dbg_num(dbg_num), .dbg_data(dbg_data)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned shv(input int unsigned v, input int sh);
      case (sh)
         1:       return (v * 2) % 65536;
         2:       return v / 2;
         3:       return v / 2 + ((v >= 32768) ? 32768 : 0);
         default: return v;
      endcase
   endfunction

   task automatic model(input int o, input int d, input int n, input int m, input int sh,
                        input int unsigned im);
      int unsigned av, bv, df;
      av = m_rf[n];
      bv = shv(m_rf[m], sh);
      case (o)
         0: m_c = im;
         1: m_c = bv;
         2: m_c = (av + bv) % 65536;
         3: begin
            df = (av + 65536 - bv) % 65536;
            m_st[0] = (df == 0);
            m_st[1] = (df >= 32768);
            m_st[2] = ((av >= 32768) != (bv >= 32768)) && ((df >= 32768) != (av >= 32768));
         end
         4: m_c = av & bv;
         5: m_c = 65535 - bv;
         default: ;
      endcase
      if (o == 0 || o == 1 || o == 2 || o == 4 || o == 5) m_rf[d] = m_c;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) m_rf[i] = 0;
      m_c  = 0;
      m_st = 3'b000;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_out"}, datapath_out, m_c);
      chk({tag, "_status"}, status, m_st);
      for (int i = 0; i < NREG; i++) begin
         dbg_num = AW'(i);
         #1;
         chk($sformatf("%s_r%0d", tag, i), dbg_data, m_rf[i]);
      end
   endtask

   task automatic read_reg(input int idx, input int unsigned exp, input string tag);
      dbg_num = AW'(idx);
      #1;
      chk(tag, dbg_data, exp);
   endtask

   task automatic issue(input int o, input int d, input int n, input int m, input int sh,
                        input int unsigned im);
      @(negedge clk);
      op = 3'(o); rd = AW'(d); rn = AW'(n); rm = AW'(m); shift = 2'(sh); imm = W'(im);
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         chk($sformatf("op%0d_busy_c%0d", o, k), busy, 1'b1);
         chk($sformatf("op%0d_done_c%0d", o, k), done, (k == 4));
      end
      model(o, d, n, m, sh, im);
      @(negedge clk);
      check_state($sformatf("op%0d", o));
   endtask

   initial begin
      int dones;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_out", datapath_out, 16'h0);
      chk("rst_status", status, 3'b000);
      for (int i = 0; i < NREG; i++) begin
         dbg_num = AW'(i);
         #1;
         chk($sformatf("rst_r%0d", i), dbg_data, 16'h0);
      end
      @(negedge clk);
      reset_n = 1'b1;

      issue(0, 0, 0, 0, 0, 7);
      issue(0, 1, 0, 0, 0, 2);
      issue(2, 2, 0, 1, 1, 0);
      read_reg(2, 16'h000B, "add_r2");
      chk("add_out", datapath_out, 16'h000B);
      chk("add_status", status, 3'b000);

      issue(3, 0, 0, 0, 0, 0);
      chk("cmp_eq", status, 3'b001);
      issue(0, 3, 0, 0, 0, 16'h8000);
      issue(0, 4, 0, 0, 0, 1);
      issue(3, 0, 3, 4, 0, 0);
      chk("cmp_ovf", status, 3'b100);
      chk("cmp_out", datapath_out, 16'h0001);

      issue(0, 5, 0, 0, 0, 16'h8004);
      issue(1, 6, 0, 5, 3, 0);
      read_reg(6, 16'hC002, "asr1");
      issue(1, 6, 0, 5, 2, 0);
      read_reg(6, 16'h4002, "lsr1");
      issue(1, 6, 0, 5, 1, 0);
      read_reg(6, 16'h0008, "lsl1");
      issue(1, 6, 0, 5, 0, 0);
      read_reg(6, 16'h8004, "noshift");
      issue(5, 7, 0, 5, 0, 0);
      read_reg(7, 16'h7FFB, "mvn");
      issue(4, 7, 5, 5, 0, 0);
      read_reg(7, 16'h8004, "and");

      @(negedge clk);
      op = 3'd0; rd = 3'd2; imm = 16'h1234; shift = 2'd0; start = 1'b1;
      @(posedge clk);
      dones = 0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 1) begin op = 3'd0; rd = 3'd3; imm = 16'h5555; end
         if (k == 6) start = 1'b0;
         dones += int'(done);
         chk($sformatf("hs_done_c%0d", k), done, (k == 4 || k == 9));
         if (k == 5) begin
            model(0, 2, 0, 0, 0, 16'h1234);
            chk("hs_idle", busy, 1'b0);
            read_reg(2, 16'h1234, "hs_r2");
         end
      end
      model(0, 3, 0, 0, 0, 16'h5555);
      @(negedge clk);
      chk("hs_done_count", dones, 2);
      check_state("hs");

      @(negedge clk);
      op = 3'd0; rd = 3'd1; imm = 16'hFFFF; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_out", datapath_out, 16'h0);
      @(negedge clk);
      chk("abort_nodone", done, 1'b0);
      reset_n = 1'b1;
      check_state("abort");
      issue(0, 1, 0, 0, 0, 16'h0055);
      read_reg(1, 16'h0055, "post_abort_r1");

      for (int t = 0; t < 40; t++) begin
         issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom & 32'hFFFF);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
